// File: rtl/bpu_update_sched_if.sv
// Handshake bundle between branch resolution, BATAGE and BFNP.
// slave: the scheduler's view. master: the environment (resolution and tables).
// Ports: upd_* intake, batage_* update port, bfnp_* training port, age_* sweep, sched_busy.
interface bpu_update_sched_if #(
  parameter int AGE_W = 10
);
  // Intake from branch resolution
  logic             upd_valid;
  logic             upd_ready;
  logic [31:0]      upd_pc;
  logic             upd_taken;
  logic             upd_mispredict;

  // BATAGE update port
  logic             batage_we;
  logic [31:0]      batage_pc;
  logic             batage_taken;
  logic             batage_alloc;

  // BFNP training port
  logic             bfnp_we;
  logic [31:0]      bfnp_pc;
  logic             bfnp_taken;
  logic             bfnp_ready;

  // Usefulness-aging sweep and status
  logic             age_we;
  logic [AGE_W-1:0] age_idx;
  logic             sched_busy;

  modport slave (
    input  upd_valid, upd_pc, upd_taken, upd_mispredict, bfnp_ready,
    output upd_ready,
    output batage_we, batage_pc, batage_taken, batage_alloc,
    output bfnp_we, bfnp_pc, bfnp_taken,
    output age_we, age_idx, sched_busy
  );

  modport master (
    output upd_valid, upd_pc, upd_taken, upd_mispredict, bfnp_ready,
    input  upd_ready,
    input  batage_we, batage_pc, batage_taken, batage_alloc,
    input  bfnp_we, bfnp_pc, bfnp_taken,
    input  age_we, age_idx, sched_busy
  );
endinterface

// File: rtl/bpu_update_sched.sv
// Update scheduler: buffers resolved-branch records and delivers each once to BATAGE and once to BFNP;
// time-shares the BATAGE write port with a periodic aging sweep. Latency: a record pushed at edge N is at head in cycle N+1.
// Backpressure: upd_ready = !full (from count only); head holds while either port has not taken it.
// Ports: clk, rst (async, active-high), bus (bpu_update_sched_if.slave).
// Optional feature: define BPU_SCHED_AGING_EN to build the age timer and S_AGE sweep.
module bpu_update_sched #(
  parameter int DEPTH      = 4,
  parameter int AGE_PERIOD = 20000,
  parameter int AGE_W      = 10
) (
  input  logic              clk,
  input  logic              rst,
  bpu_update_sched_if.slave bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  // Elaboration-time configuration guard.
  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (AGE_PERIOD < 1)) begin : g_bad_cfg
      $error("bpu_update_sched: DEPTH must be a power of two >= 2 and AGE_PERIOD >= 1");
    end
  endgenerate

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic        mispredict;
  } rec_t;

  typedef enum logic {
    S_UPD = 1'b0,
    S_AGE = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // FIFO storage and pointers
  // ---------------------------------------------------------------------------
  rec_t             mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  rec_t             head_rec;
  rec_t             in_rec;

  // Per-head delivery flags; they belong to whichever record sits at head.
  logic             batage_done;
  logic             bfnp_done;

  logic             batage_fire;
  logic             bfnp_fire;

  state_t           state;
  state_t           state_nxt;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign head_rec = mem[head];

  assign in_rec.pc         = bus.upd_pc;
  assign in_rec.taken      = bus.upd_taken;
  assign in_rec.mispredict = bus.upd_mispredict;

  // Ready depends on occupancy only, never on a same-cycle pop.
  assign bus.upd_ready = !full;
  assign push          = bus.upd_valid && !full;

  // BFNP path runs regardless of the BATAGE port FSM.
  assign bfnp_fire = !empty && !bfnp_done && bus.bfnp_ready;

  // A done flag counts if already set or being set on this edge.
  assign pop = !empty && (batage_done || batage_fire) && (bfnp_done || bfnp_fire);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= in_rec;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      batage_done <= 1'b0;
      bfnp_done   <= 1'b0;
    end else if (pop) begin
      batage_done <= 1'b0;
      bfnp_done   <= 1'b0;
    end else begin
      if (batage_fire) begin
        batage_done <= 1'b1;
      end
      if (bfnp_fire) begin
        bfnp_done <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Aging timer and sweep index
  // ---------------------------------------------------------------------------
`ifdef BPU_SCHED_AGING_EN
  localparam int TMR_W = $clog2(AGE_PERIOD + 1);

  logic [TMR_W-1:0] age_timer;
  logic [AGE_W-1:0] age_cnt;
  logic             timer_hit;
  logic             sweep_last;

  assign timer_hit  = (age_timer == TMR_W'(AGE_PERIOD - 1));
  assign sweep_last = (age_cnt == '1);

  // Timer counts S_UPD cycles and rests at 0 during the sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age_timer <= '0;
    end else if (state == S_UPD && !timer_hit) begin
      age_timer <= age_timer + 1'b1;
    end else begin
      age_timer <= '0;
    end
  end

  // Sweep index steps through every entry, then parks at 0 for the next sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age_cnt <= '0;
    end else if (state == S_AGE && !sweep_last) begin
      age_cnt <= age_cnt + 1'b1;
    end else begin
      age_cnt <= '0;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // BATAGE port FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_UPD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
`ifdef BPU_SCHED_AGING_EN
    case (state)
      S_UPD:   if (timer_hit)  state_nxt = S_AGE;
      S_AGE:   if (sweep_last) state_nxt = S_UPD;
      default: state_nxt = S_UPD;
    endcase
`else
    // Without aging the port is permanently in update mode.
    state_nxt = S_UPD;
`endif
  end

  always_comb begin
    batage_fire = 1'b0;
    bus.age_we  = 1'b0;
    bus.age_idx = '0;
    case (state)
      S_UPD: begin
        batage_fire = !empty && !batage_done;
      end
      S_AGE: begin
        bus.age_we = 1'b1;
`ifdef BPU_SCHED_AGING_EN
        bus.age_idx = age_cnt;
`endif
      end
      default: begin
        batage_fire = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Head presentation to both tables
  // ---------------------------------------------------------------------------
  assign bus.batage_we    = batage_fire;
  assign bus.batage_pc    = head_rec.pc;
  assign bus.batage_taken = head_rec.taken;
  assign bus.batage_alloc = batage_fire && head_rec.mispredict;

  assign bus.bfnp_we      = bfnp_fire;
  assign bus.bfnp_pc      = head_rec.pc;
  assign bus.bfnp_taken   = head_rec.taken;

  assign bus.sched_busy   = !empty || (state == S_AGE);

endmodule

// File: tb/tb_bpu_update_sched.sv
// Self-checking bench for bpu_update_sched: queue-based reference model checked every cycle,
// plus directed vectors with literal expectations. Works with or without BPU_SCHED_AGING_EN.
module tb_bpu_update_sched;

  localparam int DEPTH      = 4;
  localparam int AGE_PERIOD = 16;
  localparam int AGE_W      = 2;
  localparam int SWEEP_LEN  = 1 << AGE_W;
`ifdef BPU_SCHED_AGING_EN
  localparam bit AGING = 1'b1;
`else
  localparam bit AGING = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bpu_update_sched_if #(.AGE_W(AGE_W)) bus ();

  bpu_update_sched #(
    .DEPTH(DEPTH), .AGE_PERIOD(AGE_PERIOD), .AGE_W(AGE_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Cycles since reset release (0 in the release cycle).
  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // ---------------------------------------------------------------------------
  // Reference model: queue of records plus per-head delivery flags and sweep bookkeeping
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic        mis;
  } rec_t;

  rec_t q[$];
  bit   m_bd, m_fd;
  bit   m_sweep;
  int   m_idx;
  int   m_upd;
  int   age_seen = 0;

  always @(negedge clk) begin
    bit   empty, bwe, fwe, push;
    rec_t r;
    if (rst) begin
      q.delete();
      m_bd = 0; m_fd = 0; m_sweep = 0; m_idx = 0; m_upd = 0;
      chk("rst_upd_ready",  bus.upd_ready,  1);
      chk("rst_batage_we",  bus.batage_we,  0);
      chk("rst_bfnp_we",    bus.bfnp_we,    0);
      chk("rst_age_we",     bus.age_we,     0);
      chk("rst_age_idx",    bus.age_idx,    0);
      chk("rst_sched_busy", bus.sched_busy, 0);
    end else begin
      empty = (q.size() == 0);
      bwe   = !empty && !m_bd && !m_sweep;
      fwe   = !empty && !m_fd && bus.bfnp_ready;
      if (bus.age_we) age_seen++;
      chk("upd_ready",    bus.upd_ready,    q.size() < DEPTH);
      chk("batage_we",    bus.batage_we,    bwe);
      chk("bfnp_we",      bus.bfnp_we,      fwe);
      chk("batage_alloc", bus.batage_alloc, bwe && q[0].mis);
      chk("age_we",       bus.age_we,       m_sweep);
      chk("age_idx",      bus.age_idx,      m_sweep ? m_idx : 0);
      chk("sched_busy",   bus.sched_busy,   !empty || m_sweep);
      if (!empty) begin
        chk("batage_pc",    bus.batage_pc,    q[0].pc);
        chk("batage_taken", bus.batage_taken, q[0].taken);
        chk("bfnp_pc",      bus.bfnp_pc,      q[0].pc);
        chk("bfnp_taken",   bus.bfnp_taken,   q[0].taken);
      end
      // Advance the model to the state after the coming edge.
      push = bus.upd_valid && (q.size() < DEPTH);
      if (!empty) begin
        m_bd = m_bd || bwe;
        m_fd = m_fd || fwe;
        if (m_bd && m_fd) begin
          void'(q.pop_front());
          m_bd = 0;
          m_fd = 0;
        end
      end
      if (push) begin
        r.pc = bus.upd_pc; r.taken = bus.upd_taken; r.mis = bus.upd_mispredict;
        q.push_back(r);
      end
      if (AGING) begin
        if (m_sweep) begin
          if (m_idx == SWEEP_LEN - 1) begin m_sweep = 0; m_upd = 0; end
          else m_idx++;
        end else if (m_upd == AGE_PERIOD - 1) begin
          m_sweep = 1; m_idx = 0; m_upd = 0;
        end else begin
          m_upd++;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic drive(input bit v, input logic [31:0] pc, input bit t, input bit m, input bit br);
    @(posedge clk);
    #1;
    bus.upd_valid      = v;
    bus.upd_pc         = pc;
    bus.upd_taken      = t;
    bus.upd_mispredict = m;
    bus.bfnp_ready     = br;
  endtask

  task automatic wait_age(input int idx, output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (bus.age_we && (bus.age_idx == AGE_W'(idx))) begin
        ok = 1;
        return;
      end
    end
  endtask

  logic [31:0] pcs [4];
  bit          ok;

  initial begin
    bus.upd_valid = 0; bus.upd_pc = '0; bus.upd_taken = 0;
    bus.upd_mispredict = 0; bus.bfnp_ready = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #2;
    chk("lit_reset_ready", bus.upd_ready, 1);
    chk("lit_reset_busy",  bus.sched_busy, 0);
    @(posedge clk); #1; rst = 0;                       // cycle 0

    // Single record delivered to both ports in its first head cycle.
    drive(1, 32'h100, 1, 1, 1);                        // cycle 1
    drive(0, 32'h0, 0, 0, 1);                          // cycle 2
    #1;
    chk("lit_single_bwe",   bus.batage_we, 1);
    chk("lit_single_alloc", bus.batage_alloc, 1);
    chk("lit_single_fwe",   bus.bfnp_we, 1);
    chk("lit_single_pc",    bus.batage_pc, 32'h100);
    drive(0, 32'h0, 0, 0, 1);                          // cycle 3
    #1;
    chk("lit_single_idle", bus.sched_busy, 0);

    // Four back-to-back records with BFNP blocked.
    pcs[0] = 32'hA00; pcs[1] = 32'hA04; pcs[2] = 32'hA08; pcs[3] = 32'hA0C;
    drive(1, pcs[0], 0, 0, 0);                         // cycle 4
    drive(1, pcs[1], 1, 0, 0);                         // cycle 5
    #1;
    chk("lit_fill_bwe1", bus.batage_we, 1);
    chk("lit_fill_pc1",  bus.batage_pc, pcs[0]);
    drive(1, pcs[2], 0, 1, 0);                         // cycle 6
    #1;
    chk("lit_fill_hold", bus.batage_we, 0);
    drive(1, pcs[3], 1, 1, 0);                         // cycle 7
    drive(0, 32'h0, 0, 0, 0);                          // cycle 8
    #1;
    chk("lit_full_ready", bus.upd_ready, 0);
    for (int k = 0; k < 4; k++) begin                  // cycles 9..12
      drive(0, 32'h0, 0, 0, 1);
      #1;
      chk("lit_drain_fwe", bus.bfnp_we, 1);
      chk("lit_drain_pc",  bus.bfnp_pc, pcs[k]);
    end

`ifdef BPU_SCHED_AGING_EN
    // First sweep starts after 16 update-mode cycles.
    wait_age(0, ok);
    chk("lit_sweep_found", ok, 1);
    chk("lit_sweep_start", cyc, 16);
    drive(1, 32'h200, 0, 1, 1);                        // cycle 17
    #1;
    chk("lit_sweep_idx1", bus.age_idx, 1);
    drive(0, 32'h0, 0, 0, 1);                          // cycle 18
    #1;
    chk("lit_sweep_idx2", bus.age_idx, 2);
    chk("lit_sweep_fwe",  bus.bfnp_we, 1);
    chk("lit_sweep_bwe",  bus.batage_we, 0);
    drive(0, 32'h0, 0, 0, 1);                          // cycle 19
    #1;
    chk("lit_sweep_idx3", bus.age_idx, 3);
    chk("lit_sweep_bwe3", bus.batage_we, 0);
    drive(0, 32'h0, 0, 0, 1);                          // cycle 20
    #1;
    chk("lit_post_sweep_age", bus.age_we, 0);
    chk("lit_post_sweep_bwe", bus.batage_we, 1);
    chk("lit_post_sweep_pc",  bus.batage_pc, 32'h200);
    drive(0, 32'h0, 0, 0, 1);                          // cycle 21
`else
    drive(1, 32'h200, 0, 1, 1);
    drive(0, 32'h0, 0, 0, 1);
    #1;
    chk("lit_noage_bwe", bus.batage_we, 1);
    chk("lit_noage_fwe", bus.bfnp_we, 1);
    drive(0, 32'h0, 0, 0, 1);
`endif

    // Push and pop together at count = DEPTH-1; tail wraps past the end.
    pcs[0] = 32'hB00; pcs[1] = 32'hB04; pcs[2] = 32'hB08; pcs[3] = 32'hB0C;
    drive(1, pcs[0], 1, 0, 0);
    drive(1, pcs[1], 0, 0, 0);
    drive(1, pcs[2], 1, 0, 0);
    drive(1, pcs[3], 0, 1, 1);
    #1;
    chk("lit_wrap_fwe",   bus.bfnp_we, 1);
    chk("lit_wrap_pc0",   bus.bfnp_pc, pcs[0]);
    chk("lit_wrap_ready", bus.upd_ready, 1);
    for (int k = 1; k < 4; k++) begin
      drive(0, 32'h0, 0, 0, 1);
      #1;
      chk("lit_wrap_order", bus.bfnp_pc, pcs[k]);
    end
    drive(0, 32'h0, 0, 0, 0);

    // Reset with three queued records (mid-sweep when aging is built in).
    drive(1, 32'hC00, 1, 1, 0);
    drive(1, 32'hC04, 0, 1, 0);
    drive(1, 32'hC08, 1, 0, 0);
    drive(0, 32'h0, 0, 0, 0);
`ifdef BPU_SCHED_AGING_EN
    wait_age(2, ok);
    chk("lit_rst_sweep_found", ok, 1);
`else
    #1;
`endif
    chk("lit_pre_rst_busy", bus.sched_busy, 1);
    rst = 1;
    #1;
    chk("lit_rst_age_we", bus.age_we, 0);
    chk("lit_rst_ready",  bus.upd_ready, 1);
    chk("lit_rst_busy",   bus.sched_busy, 0);
    chk("lit_rst_bwe",    bus.batage_we, 0);
    @(posedge clk); #1; rst = 0;
`ifdef BPU_SCHED_AGING_EN
    wait_age(0, ok);
    chk("lit_restart_found", ok, 1);
    chk("lit_restart_cyc",   cyc, 16);
`endif

    // Long mixed run: model checks every cycle.
    age_seen = 0;
    for (int i = 0; i < 40000; i++) begin
      drive((i % 3) != 2, 32'h1000 + 32'(i) * 4, (i % 2) == 1, ((i / 2) % 2) == 1, (i % 7) != 0);
    end
    drive(0, 32'h0, 0, 0, 1);
`ifndef BPU_SCHED_AGING_EN
    chk("lit_noage_never", age_seen, 0);
`endif
    repeat (8) drive(0, 32'h0, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
